// File: rtl/alu_display_pkg.sv
// Shared definitions for the multiplexed ALU operand/result display:
// digit count, scan FSM states, snapshot layout and the hex segment table.
package alu_display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic       cout;
    } snap_t;

    // Segments a..g on bits 0..6, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
import alu_display_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/alu_scan_display.sv
// Six-digit multiplexed hex display of ALU operands A, B and result F, with
// frame-synchronous snapshot update so a frame never mixes old and new values.
import alu_display_pkg::*;

module alu_scan_display #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [7:0]            a,
    input  logic [7:0]            b,
    input  logic [7:0]            f,
    input  logic                  cout,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_done,
    output logic                  pending
);

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [2:0]            digit_q, digit_d;
    logic [15:0]           cnt_q, cnt_d;
    snap_t                 buf_q, buf_d;
    snap_t                 snap_q, snap_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

    logic                  xfer;
    logic [3:0]            nib_d;
    logic [6:0]            seg_lut;

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            digit_d = 3'd0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    digit_d = 3'd0;
                    cnt_d   = 16'd0;
                end
                ST_SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = 16'd0;
                        if (digit_q == LAST_DIGIT) begin
                            digit_d      = 3'd0;
                            frame_done_d = 1'b1;
                        end else begin
                            digit_d = digit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    digit_d = 3'd0;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        // Snapshot only moves at a frame boundary (or while idle) so a frame never tears.
        xfer = pending_q && ((state_q == ST_IDLE) ||
                             (state_q == ST_BLANK && state_d == ST_SHOW && digit_d == 3'd0));

        snap_d    = xfer ? buf_q : snap_q;
        buf_d     = load ? snap_t'{a: a, b: b, f: f, cout: cout} : buf_q;
        pending_d = load ? 1'b1 : (xfer ? 1'b0 : pending_q);
    end

    always_comb begin
        case (digit_d)
            3'd0:    nib_d = snap_d.a[3:0];
            3'd1:    nib_d = snap_d.a[7:4];
            3'd2:    nib_d = snap_d.b[3:0];
            3'd3:    nib_d = snap_d.b[7:4];
            3'd4:    nib_d = snap_d.f[3:0];
            3'd5:    nib_d = snap_d.f[7:4];
            default: nib_d = 4'h0;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nib (nib_d),
        .seg (seg_lut)
    );

    // Outputs are decoded from next-state values so they switch with the FSM edge.
    always_comb begin
        seg_d   = 7'h00;
        dp_d    = 1'b0;
        dig_n_d = '1;
        if (state_d == ST_SHOW) begin
            seg_d   = seg_lut;
            dp_d    = (digit_d == LAST_DIGIT) && snap_d.cout;
            dig_n_d = ~(NUM_DIGITS'(1) << digit_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= 3'd0;
            cnt_q        <= 16'd0;
            buf_q        <= '0;
            snap_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            dig_n_q      <= '1;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_n_q      <= dig_n_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_n      = dig_n_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_alu_scan_display.sv
// Directed scoreboard bench for alu_scan_display with DIV=4, BLANK=2.
module tb_alu_scan_display;

    localparam int DIV    = 4;
    localparam int BLANK  = 2;
    localparam int FRAME  = 6 * (DIV + BLANK);

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] a, b, f;
    logic       cout;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_n;
    logic       frame_done;
    logic       pending;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q [$];
    logic [5:0]  prev_dn = 6'h3F;
    int          lit_len = 0;
    bit          len_chk = 1'b1;
    bit          fd_valid = 1'b0;
    int          cyc = 0;
    int          last_fd = 0;

    alu_scan_display #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .a          (a),
        .b          (b),
        .f          (f),
        .cout       (cout),
        .seg        (seg),
        .dp         (dp),
        .dig_n      (dig_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] pa, input logic [7:0] pb,
                              input logic [7:0] pf, input logic pc);
        logic [3:0] nibs [6];
        nibs[0] = pa[3:0]; nibs[1] = pa[7:4];
        nibs[2] = pb[3:0]; nibs[3] = pb[7:4];
        nibs[4] = pf[3:0]; nibs[5] = pf[7:4];
        for (int i = 0; i < 6; i++)
            exp_q.push_back({~(6'd1 << i), HEX[nibs[i]], (i == 5) && pc});
    endtask

    // One clock; sample after the edge and run the scoreboard monitor.
    task automatic tick();
        logic [13:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (dig_n !== 6'h3F && prev_dn === 6'h3F) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL digit: observed %0h with no expectation queued", {dig_n, seg, dp});
            end else begin
                e = exp_q.pop_front();
                check("digit", 32'({dig_n, seg, dp}), 32'(e));
            end
            lit_len = 1;
        end else if (dig_n !== 6'h3F) begin
            lit_len++;
        end else if (prev_dn !== 6'h3F && len_chk) begin
            check("lit_len", 32'(lit_len), 32'(DIV));
        end
        if (frame_done === 1'b1) begin
            if (fd_valid) check("frame_period", 32'(cyc - last_fd), 32'(FRAME));
            fd_valid = 1'b1;
            last_fd  = cyc;
        end
        prev_dn = dig_n;
    endtask

    task automatic run_until_size(input int n);
        int budget;
        budget = 400;
        while (exp_q.size() > n && budget > 0) begin
            tick();
            budget--;
        end
        if (exp_q.size() > n) begin
            checks++;
            errors++;
            $error("FAIL timeout: queue size %0d required %0d", exp_q.size(), n);
        end
    endtask

    task automatic do_load(input logic [7:0] la, input logic [7:0] lb,
                           input logic [7:0] lf, input logic lc);
        a = la; b = lb; f = lf; cout = lc; load = 1'b1;
        tick();
        load = 1'b0;
        a = 8'($urandom); b = 8'($urandom); f = 8'($urandom); cout = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        a = 8'h00; b = 8'h00; f = 8'h00; cout = 1'b0;
        tick(); tick(); tick();
        check("rst_dig_n", 32'(dig_n), 32'h3F);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);

        // Blank snapshot: two full frames of zeros.
        rst = 1'b0; en = 1'b1;
        push_frame(8'h00, 8'h00, 8'h00, 1'b0);
        push_frame(8'h00, 8'h00, 8'h00, 1'b0);
        run_until_size(0);
        len_chk = 1'b0; en = 1'b0;
        tick();
        len_chk = 1'b1; fd_valid = 1'b0;
        check("idle_dig_n", 32'(dig_n), 32'h3F);

        // Load while idle transfers straight into the snapshot.
        do_load(8'h12, 8'hAB, 8'hBD, 1'b1);
        check("idle_load_pending", 32'(pending), 32'h1);
        tick();
        check("idle_xfer_pending", 32'(pending), 32'h0);
        push_frame(8'h12, 8'hAB, 8'hBD, 1'b1);
        en = 1'b1;
        run_until_size(0);

        // Mid-frame load at digit 2 waits for the next frame.
        push_frame(8'h12, 8'hAB, 8'hBD, 1'b1);
        run_until_size(3);
        do_load(8'h34, 8'h56, 8'h78, 1'b0);
        check("mid_load_pending", 32'(pending), 32'h1);
        push_frame(8'h34, 8'h56, 8'h78, 1'b0);
        run_until_size(6);
        check("pending_at_d5", 32'(pending), 32'h1);
        run_until_size(5);
        check("pending_at_new_d0", 32'(pending), 32'h0);
        run_until_size(0);

        // Two loads in one frame: latest wins.
        push_frame(8'h34, 8'h56, 8'h78, 1'b0);
        run_until_size(4);
        do_load(8'h9A, 8'hBC, 8'h01, 1'b0);
        run_until_size(2);
        do_load(8'h9A, 8'hBC, 8'hFF, 1'b1);
        push_frame(8'h9A, 8'hBC, 8'hFF, 1'b1);
        run_until_size(0);

        // Drop enable during digit 3, then restart at digit 0.
        push_frame(8'h9A, 8'hBC, 8'hFF, 1'b1);
        run_until_size(2);
        tick();
        len_chk = 1'b0; en = 1'b0;
        tick();
        check("en_drop_dig_n", 32'(dig_n), 32'h3F);
        check("en_drop_seg", 32'(seg), 32'h0);
        exp_q.delete();
        len_chk = 1'b1; fd_valid = 1'b0;
        tick();
        en = 1'b1;
        push_frame(8'h9A, 8'hBC, 8'hFF, 1'b1);
        tick();
        check("restart_dig_n", 32'(dig_n), 32'h3E);

        // Reset during blanking of digit 4 with a load pending.
        run_until_size(1);
        do_load(8'h55, 8'h66, 8'h77, 1'b1);
        tick(); tick(); tick();
        check("blank_d4_dig_n", 32'(dig_n), 32'h3F);
        check("pre_rst_pending", 32'(pending), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        fd_valid = 1'b0;
        check("mid_rst_dig_n", 32'(dig_n), 32'h3F);
        check("mid_rst_seg", 32'(seg), 32'h0);
        check("mid_rst_dp", 32'(dp), 32'h0);
        check("mid_rst_frame_done", 32'(frame_done), 32'h0);
        check("mid_rst_pending", 32'(pending), 32'h0);
        push_frame(8'h00, 8'h00, 8'h00, 1'b0);
        run_until_size(0);
        len_chk = 1'b0; en = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_scan_display.md
ALU_SCAN_DISPLAY -- requirements
Module: alu_scan_display

Interface
REQ-001 Parameter DIV, default 1000, clock cycles each digit is lit (legal 2..65535).
REQ-002 Parameter BLANK, default 16, all-digits-off cycles between digits for anti-ghosting (legal 1..255).
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  scan enable; 0 forces display dark.
REQ-006 load  input  1  single-cycle request to snapshot operands/result.
REQ-007 a  input  8  ALU operand A.
REQ-008 b  input  8  ALU operand B.
REQ-009 f  input  8  ALU result F from the cascaded 74181 pair.
REQ-010 cout  input  1  carry out of the upper ALU slice.
REQ-011 seg  output  7  segments a..g on bits 0..6, active-high.
REQ-012 dp  output  1  decimal point, active-high.
REQ-013 dig_n  output  6  digit enables, active-low, one-hot-low while lit.
REQ-014 frame_done  output  1  one-cycle pulse at end of each full scan.
REQ-015 pending  output  1  snapshot requested but not yet applied.

Function
REQ-016 Digit index 0..5 SHALL show a[3:0], a[7:4], b[3:0], b[7:4], f[3:0], f[7:4]; dig_n[i] low for digit i.
REQ-017 Nibble-to-segment map SHALL be standard hex 0-F (0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71).
REQ-018 dp SHALL be 1 only while digit 5 is lit and snapshot cout is 1.
REQ-019 FSM states IDLE, SHOW, BLANKING; IDLE->SHOW(digit 0) on en=1; SHOW->BLANKING after exactly DIV cycles; BLANKING->SHOW(next digit) after exactly BLANK cycles.
REQ-020 Digit index SHALL wrap 5->0; frame_done SHALL pulse on the cycle BLANKING of digit 5 ends.
REQ-021 Frame period SHALL be exactly 6*(DIV+BLANK) cycles while en=1.
REQ-022 In IDLE and BLANKING: dig_n=6'h3F, seg=0, dp=0.
REQ-023 seg/dp/dig_n SHALL be flop outputs changing on the same edge as the FSM state (no extra latency).
REQ-024 load SHALL capture a,b,f,cout into a pending buffer and set pending=1 on the next edge.
REQ-025 Pending buffer SHALL transfer to display snapshot only on entry to SHOW digit 0 or while in IDLE; pending clears on that edge (no mid-frame tearing).
REQ-026 load while pending=1 SHALL overwrite the buffer (latest wins); load coincident with transfer SHALL leave pending=1 with the new values.
REQ-027 en deassert in any state SHALL enter IDLE next edge, digit index and counters to 0; re-enable restarts at digit 0.
REQ-028 Inputs a/b/f/cout SHALL be ignored except on load cycles.

Reset
REQ-029 On rst=1: state IDLE, digit index 0, all counters 0, buffer and snapshot 0, pending 0, dig_n=6'h3F, seg=0, dp=0, frame_done=0.
REQ-030 rst SHALL take priority over en and load in the same cycle; reset mid-frame aborts immediately.

Structure
REQ-031 Shared package alu_display_pkg SHALL hold NUM_DIGITS=6, the state enum, and the 16-entry hex segment table.
REQ-032 One combinational sub-module hex_to_seg7 (4-bit in, 7-bit out) SHALL implement the table; everything else in alu_scan_display.

Verification (DIV=4, BLANK=2)
REQ-033 Reset, en=1, no load -> every digit shows 7'h3F, dig_n sequence 3E,3F,3D,3F,... , frame_done every 36 cycles.
REQ-034 load with a=8'h12,b=8'hAB,f=8'hBD,cout=1 while IDLE -> digits show 2,1,B,A,D,B; dp=1 only on digit 5.
REQ-035 load at digit 2 mid-frame -> old values until end of digit 5, new values from next digit 0; pending high in between.
REQ-036 Two loads in one frame (f=8'h01 then f=8'hFF) -> only FF displayed next frame.
REQ-037 en dropped during digit 3 SHOW -> dig_n=6'h3F next cycle; en raised -> digit 0 lit for 4 cycles.
REQ-038 rst pulsed during BLANKING of digit 4 -> all outputs at reset values next cycle, pending=0, snapshot 0.
